// File: rtl/pool_engine_v2.sv
// Streaming non-overlapping PxP max/average pooling over an MxM row-major
// feature map; C independent lane datapaths share one window controller.
module pool_engine_v2 #(
   parameter int             M         = 12,
   parameter int             P         = 3,
   parameter int             N         = 16,
   parameter int             Q         = 12,
   parameter int             C         = 1,
   parameter logic [N-1:0]   P_SQR_INV = 16'h01C7
) (
   input  logic             clk,
   input  logic             master_rst,
   input  logic             ce,
   input  logic             flush,
   input  logic             mode,
   input  logic [C*N-1:0]   data_in,
   output logic [C*N-1:0]   data_out,
   output logic             valid_op,
   output logic             end_op,
   output logic             busy
);
   localparam int NW  = M / P;
   localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
   localparam int CXW = $clog2(P);
   localparam int AW  = N + $clog2(P * P);
   localparam int PW  = AW + N + 1;
   localparam logic signed [PW-1:0] HALF    = PW'(64'd1 << (Q - 1));
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(PW-N+1){1'b1}}, {(N-1){1'b0}}};

   // Scale the window sum by 1/(P*P), round half up, clamp to N-bit signed.
   function automatic logic [N-1:0] avg_sat(input logic signed [AW-1:0] sum);
      logic signed [PW-1:0] w_prod;
      logic signed [PW-1:0] w_shr;
      logic [N-1:0]         w_res;
      w_prod = PW'(sum) * $signed({{(PW-N){1'b0}}, P_SQR_INV});
      w_shr  = (w_prod + HALF) >>> Q;
      if (w_shr > SAT_MAX)
         w_res = SAT_MAX[N-1:0];
      else if (w_shr < SAT_MIN)
         w_res = SAT_MIN[N-1:0];
      else
         w_res = w_shr[N-1:0];
      return w_res;
   endfunction

   logic [CXW-1:0] r_cx, r_ry;
   logic [WW-1:0]  r_w, r_wr;
   logic           r_mode, r_busy;
   logic           r_fin_vld, r_fin_end, r_fin_mode;
   logic           r_valid, r_end;
   logic           w_acc, w_first, w_last_col, w_row_end, w_final, w_frame_end, w_mode;

   assign w_acc       = ce && !flush;
   assign w_first     = (r_cx == '0) && (r_w == '0) && (r_ry == '0) && (r_wr == '0);
   assign w_last_col  = (r_cx == CXW'(P - 1));
   assign w_row_end   = w_last_col && (r_w == WW'(NW - 1));
   assign w_final     = w_last_col && (r_ry == CXW'(P - 1));
   assign w_frame_end = w_final && (r_w == WW'(NW - 1)) && (r_wr == WW'(NW - 1));
   // The frame's first element already obeys the mode sampled with it.
   assign w_mode      = w_first ? mode : r_mode;

   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         r_cx   <= '0;
         r_w    <= '0;
         r_ry   <= '0;
         r_wr   <= '0;
         r_mode <= 1'b1;
      end else if (flush) begin
         r_cx <= '0;
         r_w  <= '0;
         r_ry <= '0;
         r_wr <= '0;
      end else if (ce) begin
         if (w_first)
            r_mode <= mode;
         r_cx <= w_last_col ? '0 : r_cx + 1'b1;
         if (w_row_end) begin
            r_w <= '0;
            if (r_ry == CXW'(P - 1)) begin
               r_ry <= '0;
               r_wr <= (r_wr == WW'(NW - 1)) ? '0 : r_wr + 1'b1;
            end else begin
               r_ry <= r_ry + 1'b1;
            end
         end else if (w_last_col) begin
            r_w <= r_w + 1'b1;
         end
      end
   end

   // Stage p0 -> p1: a finished window issues one cycle later regardless of
   // ce or flush, so a result already computed is never lost.
   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         r_fin_vld  <= 1'b0;
         r_fin_end  <= 1'b0;
         r_fin_mode <= 1'b1;
         r_valid    <= 1'b0;
         r_end      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_fin_vld <= w_acc && w_final;
         r_fin_end <= w_acc && w_frame_end;
         if (w_acc && w_final)
            r_fin_mode <= w_mode;
         r_valid <= r_fin_vld;
         r_end   <= r_fin_vld && r_fin_end;
         if (flush)
            r_busy <= 1'b0;
         else if (w_acc && w_first)
            r_busy <= 1'b1;
         else if (r_fin_vld && r_fin_end)
            r_busy <= 1'b0;
      end
   end

   for (genvar k = 0; k < C; k++) begin : g_lane
      logic signed [N-1:0]  w_d;
      logic signed [AW-1:0] w_dx, w_opnd, w_f;
      logic signed [AW-1:0] r_acc, r_fin;
      logic signed [AW-1:0] r_lbuf [NW];
      logic [N-1:0]         r_out;

      assign w_d    = data_in[k*N +: N];
      assign w_dx   = AW'(w_d);
      // First column of a window row continues from the partial result
      // parked in the line buffer by the rows above.
      assign w_opnd = (r_cx == '0) ? r_lbuf[r_w] : r_acc;

      always_comb begin
         w_f = w_dx;
         if (!((r_cx == '0) && (r_ry == '0))) begin
            if (w_mode)
               w_f = (w_dx > w_opnd) ? w_dx : w_opnd;
            else
               w_f = w_dx + w_opnd;
         end
      end

      always_ff @(posedge clk) begin
         if (w_acc) begin
            r_acc <= w_f;
            if (w_last_col && (r_ry != CXW'(P - 1)))
               r_lbuf[r_w] <= w_f;
            if (w_final)
               r_fin <= w_f;
         end
      end

      always_ff @(posedge clk or negedge master_rst) begin
         if (!master_rst)
            r_out <= '0;
         else if (r_fin_vld)
            r_out <= r_fin_mode ? r_fin[N-1:0] : avg_sat(r_fin);
      end

      assign data_out[k*N +: N] = r_out;
   end

   assign valid_op = r_valid;
   assign end_op   = r_end;
   assign busy     = r_busy;

endmodule

// File: tb/tb_pool_engine_v2.sv
// Bench for pool_engine_v2: table vectors plus randomized frames checked
// against a window-level arithmetic model of the pooling rules.
module tb_pool_engine_v2;
   localparam int MM = 4;
   localparam int PP = 2;
   localparam int NN = 16;
   localparam int QQ = 12;
   localparam int CC = 2;
   localparam int FE = MM * MM;
   localparam int NWIN = (MM / PP) * (MM / PP);
   localparam logic [15:0] INV   = 16'h0400;
   localparam logic [15:0] INV_S = 16'h0800;

   typedef struct {
      bit                     mx;
      logic [FE-1:0][15:0]    din;
      logic [NWIN-1:0][15:0]  exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             master_rst, ce, flush, mode;
   logic [CC*NN-1:0] data_in, data_out;
   logic             valid_op, end_op, busy;
   logic [NN-1:0]    data_in_s, data_out_s;
   logic             valid_s, end_s, busy_s;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_end = 0;
   logic [15:0] fr0 [FE];
   logic [15:0] fr1 [FE];
   logic [15:0] q_e0[$], q_e1[$], q_es[$], got0[$];
   bit          q_end[$];
   int          q_cyc[$];
   vec_t        tbl [4];

   pool_engine_v2 #(.M(MM), .P(PP), .N(NN), .Q(QQ), .C(CC), .P_SQR_INV(INV)) dut (
      .clk(clk), .master_rst(master_rst), .ce(ce), .flush(flush), .mode(mode),
      .data_in(data_in), .data_out(data_out), .valid_op(valid_op),
      .end_op(end_op), .busy(busy));

   pool_engine_v2 #(.M(MM), .P(PP), .N(NN), .Q(QQ), .C(1), .P_SQR_INV(INV_S)) dut_s (
      .clk(clk), .master_rst(master_rst), .ce(ce), .flush(flush), .mode(mode),
      .data_in(data_in_s), .data_out(data_out_s), .valid_op(valid_s),
      .end_op(end_s), .busy(busy_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] avg_ref(input longint s, input longint inv);
      longint r;
      r = (s * inv + (longint'(1) << (QQ - 1))) >>> QQ;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   function automatic logic [15:0] model_win(input int lane, input int wr, input int wc, input bit mx);
      longint s, m, v;
      int idx;
      s = 0;
      m = -(longint'(1) << 40);
      for (int dy = 0; dy < PP; dy++) begin
         for (int dx = 0; dx < PP; dx++) begin
            idx = (wr * PP + dy) * MM + wc * PP + dx;
            v = (lane == 0) ? longint'($signed(fr0[idx])) : longint'($signed(fr1[idx]));
            s += v;
            if (v > m) m = v;
         end
      end
      return mx ? 16'(m) : avg_ref(s, longint'(INV));
   endfunction

   always @(negedge clk) begin
      if (master_rst && valid_op) begin
         if (end_op) n_end++;
         got0.push_back(data_out[15:0]);
         if (q_e0.size() == 0) begin
            check("unexpected_valid", 32'(valid_op), 32'd0);
         end else begin
            check("lane0_model", data_out[15:0], q_e0.pop_front());
            check("lane1_model", data_out[31:16], q_e1.pop_front());
            check("sat_lane", data_out_s, q_es.pop_front());
            check("sat_valid", 32'(valid_s), 32'd1);
            check("end_op", 32'(end_op), 32'(q_end.pop_front()));
            check("latency", cyc, q_cyc.pop_front() + 1);
         end
      end else if (master_rst && end_op) begin
         check("end_without_valid", 32'(end_op), 32'd0);
      end
   end

   task automatic idle(input int n);
      ce = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input bit mode_v, input int stall_pct, input bit toggle, input int n_elem);
      int r, c;
      for (int i = 0; i < n_elem; i++) begin
         while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            ce = 1'b0;
            data_in = $urandom;
            @(posedge clk);
            #1;
         end
         mode = (toggle && i >= FE / 2) ? ~mode_v : mode_v;
         ce = 1'b1;
         data_in = {fr1[i], fr0[i]};
         @(posedge clk);
         #1;
         if (i == 0) check("busy_on_first", 32'(busy), 32'd1);
         r = i / MM;
         c = i % MM;
         if ((c % PP) == PP - 1 && (r % PP) == PP - 1) begin
            q_e0.push_back(model_win(0, r / PP, c / PP, mode_v));
            q_e1.push_back(model_win(1, r / PP, c / PP, mode_v));
            q_es.push_back(mode_v ? 16'h7000
                                  : avg_ref(longint'(PP * PP) * longint'(16'h7000), longint'(INV_S)));
            q_end.push_back(r == MM - 1 && c == MM - 1);
            q_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic load_vec(input int j);
      for (int i = 0; i < FE; i++) begin
         fr0[i] = tbl[j].din[i];
         fr1[i] = 16'($urandom);
      end
   endtask

   task automatic load_rand();
      for (int i = 0; i < FE; i++) begin
         fr0[i] = 16'($urandom);
         fr1[i] = 16'($urandom);
      end
   endtask

   task automatic run_vec(input int j, input int stall_pct);
      got0.delete();
      load_vec(j);
      drive_frame(tbl[j].mx, stall_pct, 1'b0, FE);
      idle(4);
      check("busy_after_frame", 32'(busy), 32'd0);
      check("pending_outputs", q_e0.size(), 32'd0);
      check("result_count", got0.size(), NWIN);
      for (int w = 0; w < NWIN && w < got0.size(); w++)
         check("table_out", got0[w], tbl[j].exp[w]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int r, c;
      for (int i = 0; i < FE; i++) begin
         r = i / MM;
         c = i % MM;
         tbl[0].din[i] = 16'((i + 1) << 10);
         tbl[1].din[i] = 16'((i + 1) << 10);
         tbl[2].din[i] = 16'h8000;
         tbl[3].din[i] = (r % 2 == 0) ? ((c % 2 == 0) ? 16'hF000 : 16'hD000)
                                      : ((c % 2 == 0) ? 16'hE000 : 16'hC000);
      end
      tbl[0].mx = 1'b1; tbl[0].exp = {16'h4000, 16'h3800, 16'h2000, 16'h1800};
      tbl[1].mx = 1'b0; tbl[1].exp = {16'h3600, 16'h2E00, 16'h1600, 16'h0E00};
      tbl[2].mx = 1'b0; tbl[2].exp = {4{16'h8000}};
      tbl[3].mx = 1'b1; tbl[3].exp = {4{16'hF000}};

      master_rst = 1'b0;
      ce = 1'b0;
      flush = 1'b0;
      mode = 1'b0;
      data_in = '0;
      data_in_s = 16'h7000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_out", data_out, 32'd0);
      check("rst_valid", 32'(valid_op), 32'd0);
      check("rst_end", 32'(end_op), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      master_rst = 1'b1;
      @(posedge clk);
      #1;

      for (int j = 0; j < 4; j++) run_vec(j, 0);
      run_vec(0, 40);
      run_vec(1, 40);

      // Back-to-back frames, mode toggled mid-frame in the first one.
      got0.delete();
      e0 = n_end;
      load_vec(0);
      drive_frame(1'b1, 0, 1'b1, FE);
      load_vec(1);
      drive_frame(1'b0, 0, 1'b0, FE);
      idle(4);
      check("b2b_end_count", n_end - e0, 32'd2);
      check("b2b_count", got0.size(), 2 * NWIN);
      for (int w = 0; w < 2 * NWIN && w < got0.size(); w++)
         check("b2b_out", got0[w], (w < NWIN) ? tbl[0].exp[w] : tbl[1].exp[w - NWIN]);
      check("b2b_busy", 32'(busy), 32'd0);

      // Mid-frame flush with a simultaneous element that must be dropped.
      load_rand();
      drive_frame(1'b1, 0, 1'b0, 5);
      flush = 1'b1;
      ce = 1'b1;
      data_in = $urandom;
      @(posedge clk);
      #1;
      flush = 1'b0;
      ce = 1'b0;
      check("busy_after_flush", 32'(busy), 32'd0);
      idle(4);
      check("flush_no_output", q_e0.size(), 32'd0);
      load_rand();
      drive_frame(1'($urandom), 0, 1'b0, FE);
      idle(4);
      check("flush_recover", q_e0.size(), 32'd0);

      // Asynchronous reset mid-frame.
      load_rand();
      drive_frame(1'b0, 0, 1'b0, 5);
      ce = 1'b0;
      #2;
      master_rst = 1'b0;
      #1;
      check("async_data_out", data_out, 32'd0);
      check("async_valid", 32'(valid_op), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_sat_out", data_out_s, 32'd0);
      @(negedge clk);
      master_rst = 1'b1;
      @(posedge clk);
      #1;
      load_rand();
      drive_frame(1'b1, 0, 1'b0, FE);
      idle(4);
      check("reset_recover", q_e0.size(), 32'd0);

      // Randomized frames, stalls and back-to-back streaming.
      for (int f = 0; f < 8; f++) begin
         load_rand();
         drive_frame(1'($urandom), ($urandom_range(1) == 1) ? 40 : 0, 1'($urandom), FE);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(3)) + 1);
      end
      idle(4);
      check("random_pending", q_e0.size(), 32'd0);
      check("random_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
